nios_system_cpu_ocimem_engine: RTL and testbench

Debug-memory engine directly downstream of the CPU JTAG debug module's system-clock stage. It consumes that stage's jdo bus and single-cycle take_action_ocimem_a/b and take_no_action_ocimem_a strobes. It performs host reads and writes into a private on-chip debug RAM, returns read data and monitor status as MonDReg, monitor_ready and monitor_error, and shares the RAM with the CPU's debug monitor through an Avalon-MM slave.

---
 rtl/nios_system_cpu_ocimem_engine.sv | 113 +++++++++++
 tb/tb_nios_system_cpu_ocimem_engine.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/nios_system_cpu_ocimem_engine.sv
// nios_system_cpu_ocimem_engine: JTAG-driven debug RAM engine shared with the CPU over Avalon-MM
module nios_system_cpu_ocimem_engine #(
    parameter int ADDR_W     = 8,
    parameter bit INIT_READY = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    input  logic [ADDR_W:0]   avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic              avs_readdatavalid,
    output logic              avs_waitrequest
);
    typedef enum logic [2:0] {IDLE, J_RD, J_CAP, J_WR, C_RD, C_CAP} state_t;

    state_t            r_state, w_next;
    logic [31:0]       r_mem [2**ADDR_W];
    logic [31:0]       r_q, r_pw_data, w_wdata;
    logic [ADDR_W-1:0] r_mon_a, w_addr;
    logic              r_pw, r_pr, r_cctl;
    logic              w_rd_stb, w_wait, w_cpu_rd, w_cpu_wr, w_cpu_ctl, w_we;
    logic              w_unused;

    assign w_unused        = ^{jdo[37:36], jdo[33:32]};
    assign w_rd_stb        = (take_action_ocimem_a | take_no_action_ocimem_a) & jdo[34];
    assign w_wait          = (r_state != IDLE) | r_pw | r_pr;
    assign avs_waitrequest = w_wait;
    assign w_cpu_rd        = avs_read & !w_wait;
    assign w_cpu_wr        = avs_write & !avs_read & !w_wait;
    assign w_cpu_ctl       = avs_address[ADDR_W];

    // Arbitration and RAM port steering: latched JTAG work first, then CPU, then fresh strobes
    always_comb begin
        w_next  = r_state;
        w_we    = 1'b0;
        w_addr  = avs_address[ADDR_W-1:0];
        w_wdata = avs_writedata;
        case (r_state)
            IDLE: begin
                if (r_pw)                      w_next = J_WR;
                else if (r_pr)                 w_next = J_RD;
                else if (w_cpu_rd)             w_next = C_RD;
                else if (w_cpu_wr)             w_we   = !w_cpu_ctl;
                else if (take_action_ocimem_b) w_next = J_WR;
                else if (w_rd_stb)             w_next = J_RD;
            end
            J_WR: begin
                w_we    = 1'b1;
                w_addr  = r_mon_a;
                w_wdata = r_pw_data;
                w_next  = IDLE;
            end
            J_RD: begin
                w_addr = r_mon_a;
                w_next = J_CAP;
            end
            J_CAP:   w_next = IDLE;
            C_RD:    w_next = C_CAP;
            C_CAP:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Debug RAM: single port, registered read, not reset
    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_addr] <= w_wdata;
        r_q <= r_mem[w_addr];
    end

    // State, pending latches, monitor address/data and CPU read return
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state           <= IDLE;
            r_pw              <= 1'b0;
            r_pw_data         <= '0;
            r_pr              <= 1'b0;
            r_cctl            <= 1'b0;
            r_mon_a           <= '0;
            MonDReg           <= '0;
            monitor_ready     <= INIT_READY;
            monitor_error     <= 1'b0;
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
        end else begin
            r_state <= w_next;
            if (take_action_ocimem_b) begin
                r_pw      <= 1'b1;
                r_pw_data <= jdo[31:0];
            end else if (r_state == J_WR) r_pw <= 1'b0;
            r_pr    <= w_rd_stb | (r_pr & (r_state != J_RD));
            r_mon_a <= take_action_ocimem_a ? jdo[17 +: ADDR_W] :
                       (r_state == J_WR || r_state == J_CAP) ? r_mon_a + ADDR_W'(1) : r_mon_a;
            if (r_state == J_CAP) MonDReg <= r_q;
            if (w_cpu_rd) r_cctl <= w_cpu_ctl;
            if (r_state == C_RD) avs_readdata <= r_cctl ? {30'b0, monitor_error, monitor_ready} : r_q;
            avs_readdatavalid <= (r_state == C_RD);
            if (w_cpu_wr && w_cpu_ctl) {monitor_error, monitor_ready} <= avs_writedata[1:0];
            else if (take_action_ocimem_a && jdo[35]) {monitor_error, monitor_ready} <= 2'b00;
        end
    end

    a_pw_overwrite: assert property (@(posedge clk) disable iff (reset) !(take_action_ocimem_b && r_pw));
    a_pr_overwrite: assert property (@(posedge clk) disable iff (reset) !(w_rd_stb && r_pr));
endmodule

// File: tb/tb_nios_system_cpu_ocimem_engine.sv
// tb_nios_system_cpu_ocimem_engine: directed checks of JTAG/CPU debug RAM engine
module tb_nios_system_cpu_ocimem_engine;
    logic        clk = 1'b0, reset = 1'b1;
    logic [37:0] jdo = '0;
    logic        ta = 1'b0, tn = 1'b0, tb = 1'b0;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;
    logic [8:0]  avs_address = '0;
    logic        avs_read = 1'b0, avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid, avs_waitrequest;
    logic [31:0] d;
    int          checks = 0, errors = 0;

    nios_system_cpu_ocimem_engine #(.ADDR_W(8), .INIT_READY(1'b0)) dut (
        .clk(clk), .reset(reset), .jdo(jdo),
        .take_action_ocimem_a(ta), .take_no_action_ocimem_a(tn), .take_action_ocimem_b(tb),
        .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .avs_readdatavalid(avs_readdatavalid), .avs_waitrequest(avs_waitrequest)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic stb_a(input logic [7:0] a, input logic rd, input logic clr);
        jdo = '0;
        jdo[17 +: 8] = a;
        jdo[34] = rd;
        jdo[35] = clr;
        ta = 1'b1;
        step();
        ta = 1'b0;
    endtask

    task automatic stb_b(input logic [31:0] v);
        jdo = '0;
        jdo[31:0] = v;
        tb = 1'b1;
        step();
        tb = 1'b0;
        repeat (8) step();
    endtask

    task automatic cpu_write(input logic [8:0] a, input logic [31:0] v);
        int n = 0;
        avs_address = a;
        avs_writedata = v;
        avs_write = 1'b1;
        while (avs_waitrequest && n < 50) begin step(); n++; end
        step();
        avs_write = 1'b0;
    endtask

    task automatic cpu_read(input logic [8:0] a, output logic [31:0] v);
        int n = 0;
        avs_address = a;
        avs_read = 1'b1;
        while (avs_waitrequest && n < 50) begin step(); n++; end
        step();
        avs_read = 1'b0;
        n = 0;
        while (!avs_readdatavalid && n < 10) begin step(); n++; end
        chk("rd_latency", 32'(n), 32'd1);
        v = avs_readdata;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) step();
        chk("rst_mondreg", MonDReg, 32'h0);
        chk("rst_ready", 32'(monitor_ready), 32'h0);
        chk("rst_error", 32'(monitor_error), 32'h0);
        chk("rst_rdata", avs_readdata, 32'h0);
        chk("rst_rvalid", 32'(avs_readdatavalid), 32'h0);
        chk("rst_wait", 32'(avs_waitrequest), 32'h0);
        reset = 1'b0;
        step();
        chk("rst_state", 32'(dut.r_state), 32'd0);

        stb_a(8'h10, 1'b0, 1'b0);
        stb_b(32'hDEADBEEF);
        stb_a(8'h10, 1'b1, 1'b0);
        step();
        chk("wr_md_early", MonDReg, 32'h0);
        step();
        chk("wr_md", MonDReg, 32'hDEADBEEF);
        chk("wr_mona", 32'(dut.r_mon_a), 32'h11);

        stb_a(8'hFE, 1'b0, 1'b0);
        stb_b(32'hA1A1A1A1);
        stb_b(32'hA2A2A2A2);
        stb_b(32'hA3A3A3A3);
        chk("wrap_mona", 32'(dut.r_mon_a), 32'h01);
        cpu_read(9'h0FE, d);
        chk("wrap_fe", d, 32'hA1A1A1A1);
        cpu_read(9'h0FF, d);
        chk("wrap_ff", d, 32'hA2A2A2A2);
        cpu_read(9'h000, d);
        chk("wrap_00", d, 32'hA3A3A3A3);

        stb_a(8'h30, 1'b0, 1'b0);
        stb_b(32'hCAFEF00D);
        cpu_write(9'h020, 32'h12345678);
        stb_a(8'h30, 1'b0, 1'b0);
        repeat (2) step();
        jdo = '0;
        jdo[34] = 1'b1;
        tn = 1'b1;
        step();
        tn = 1'b0;
        avs_address = 9'h020;
        avs_read = 1'b1;
        chk("arb_wait_jrd", 32'(avs_waitrequest), 32'h1);
        step();
        chk("arb_wait_jcap", 32'(avs_waitrequest), 32'h1);
        step();
        chk("arb_wait_idle", 32'(avs_waitrequest), 32'h0);
        chk("arb_md", MonDReg, 32'hCAFEF00D);
        step();
        avs_read = 1'b0;
        chk("arb_rv_crd", 32'(avs_readdatavalid), 32'h0);
        step();
        chk("arb_rv_ccap", 32'(avs_readdatavalid), 32'h1);
        chk("arb_rdata", avs_readdata, 32'h12345678);
        step();
        chk("arb_rv_after", 32'(avs_readdatavalid), 32'h0);

        cpu_write(9'h100, 32'h3);
        chk("ctl_ready_set", 32'(monitor_ready), 32'h1);
        chk("ctl_error_set", 32'(monitor_error), 32'h1);
        stb_a(8'h00, 1'b0, 1'b1);
        chk("ctl_ready_clr", 32'(monitor_ready), 32'h0);
        chk("ctl_error_clr", 32'(monitor_error), 32'h0);
        cpu_write(9'h100, 32'h3);
        avs_address = 9'h100;
        avs_writedata = 32'h1;
        avs_write = 1'b1;
        jdo = '0;
        jdo[35] = 1'b1;
        ta = 1'b1;
        step();
        ta = 1'b0;
        avs_write = 1'b0;
        chk("ctl_race_ready", 32'(monitor_ready), 32'h1);
        chk("ctl_race_error", 32'(monitor_error), 32'h0);
        cpu_read(9'h1FF, d);
        chk("ctl_read", d, 32'h1);

        stb_a(8'h50, 1'b0, 1'b0);
        cpu_write(9'h040, 32'h0BADF00D);
        avs_address = 9'h040;
        avs_read = 1'b1;
        step();
        avs_read = 1'b0;
        jdo = '0;
        jdo[31:0] = 32'h55AA55AA;
        tb = 1'b1;
        step();
        tb = 1'b0;
        chk("pend_rv", 32'(avs_readdatavalid), 32'h1);
        chk("pend_rdata", avs_readdata, 32'h0BADF00D);
        step();
        chk("pend_state_idle", 32'(dut.r_state), 32'd0);
        chk("pend_wait", 32'(avs_waitrequest), 32'h1);
        step();
        chk("pend_state_jwr", 32'(dut.r_state), 32'd3);
        step();
        stb_a(8'h50, 1'b1, 1'b0);
        repeat (2) step();
        chk("pend_md", MonDReg, 32'h55AA55AA);

        cpu_write(9'h100, 32'h1);
        stb_a(8'h10, 1'b1, 1'b0);
        step();
        chk("arst_in_jcap", 32'(dut.r_state), 32'd2);
        #2 reset = 1'b1;
        #1;
        chk("arst_md", MonDReg, 32'h0);
        chk("arst_ready", 32'(monitor_ready), 32'h0);
        chk("arst_rdata", avs_readdata, 32'h0);
        chk("arst_rvalid", 32'(avs_readdatavalid), 32'h0);
        step();
        reset = 1'b0;
        step();
        chk("arst_state", 32'(dut.r_state), 32'd0);
        chk("arst_md_after", MonDReg, 32'h0);
        chk("arst_rvalid_after", 32'(avs_readdatavalid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
